// File: rtl/bp_piton_l15_ret_responder.sv
// Receive side of the BlackParrot/OpenPiton L1.5 bridge: pairs L1.5 returns with the pending
// request header and streams the returned data as 64-bit memory-response beats.
module bp_piton_l15_ret_responder #(
    parameter int unsigned paddr_width_p    = 40,
    parameter int unsigned l15_data_width_p = 256,
    parameter int unsigned beat_width_p     = 64,
    parameter int unsigned max_beats_p      = l15_data_width_p / beat_width_p
) (
    input  logic                        clk_i,
    input  logic                        rst_n_i,

    input  logic                        hdr_v_i,
    input  logic [paddr_width_p-1:0]    hdr_addr_i,
    input  logic [2:0]                  hdr_size_i,
    output logic                        hdr_yumi_o,

    input  logic                        l15_ret_val_i,
    input  logic [3:0]                  l15_ret_type_i,
    input  logic [l15_data_width_p-1:0] l15_ret_data_i,
    input  logic [paddr_width_p-1:0]    l15_ret_inv_addr_i,
    output logic                        l15_ret_yumi_o,

    output logic                        resp_v_o,
    input  logic                        resp_ready_and_i,
    output logic [paddr_width_p-1:0]    resp_addr_o,
    output logic [2:0]                  resp_size_o,
    output logic [beat_width_p-1:0]     resp_data_o,
    output logic                        resp_last_o,
    output logic                        resp_ack_only_o,

    output logic                        inv_v_o,
    output logic [paddr_width_p-1:0]    inv_addr_o,
    input  logic                        inv_ready_and_i,

    output logic                        err_o
);

    localparam int unsigned cnt_width_lp = (max_beats_p > 1) ? $clog2(max_beats_p) : 1;

    localparam logic [3:0] load_ret_lp  = 4'b0000;
    localparam logic [3:0] ifill_ret_lp = 4'b0001;
    localparam logic [3:0] inv_ret_lp   = 4'b0011;
    localparam logic [3:0] st_ack_lp    = 4'b0100;

    typedef enum logic [1:0] {e_idle, e_stream, e_inv} state_e;

    state_e                                      state_q, state_d;
    logic [cnt_width_lp-1:0]                     beat_q, last_idx_q, last_idx_d;
    logic [max_beats_p-1:0][beat_width_p-1:0]    data_q;
    logic [paddr_width_p-1:0]                    addr_q, inv_addr_q;
    logic [2:0]                                  size_q;
    logic [3:0]                                  type_q;
    logic                                        err_q, err_d;
    logic                                        capture, inv_capture;
    logic                                        is_data_ret, streaming, last_beat;
    logic                                        ack_only, single_load;
    logic [cnt_width_lp-1:0]                     lane;

    assign is_data_ret = (l15_ret_type_i == load_ret_lp) || (l15_ret_type_i == ifill_ret_lp)
                      || (l15_ret_type_i == st_ack_lp);

    always_comb begin
        if (l15_ret_type_i == ifill_ret_lp) begin
            last_idx_d = cnt_width_lp'(max_beats_p - 1);
        end else if ((l15_ret_type_i == load_ret_lp) && (hdr_size_i >= 3'd4)) begin
            // dcache fills are at most 128 bits, so loads top out at two beats
            last_idx_d = cnt_width_lp'(1);
        end else begin
            last_idx_d = '0;
        end
    end

    assign streaming = (state_q == e_stream);
    assign last_beat = (beat_q == last_idx_q);

    always_comb begin
        state_d        = state_q;
        capture        = 1'b0;
        inv_capture    = 1'b0;
        err_d          = 1'b0;
        l15_ret_yumi_o = 1'b0;
        hdr_yumi_o     = 1'b0;
        resp_v_o       = 1'b0;
        inv_v_o        = 1'b0;
        unique case (state_q)
            e_idle: begin
                if (l15_ret_val_i) begin
                    l15_ret_yumi_o = 1'b1;
                    if (is_data_ret) begin
                        if (hdr_v_i) begin
                            hdr_yumi_o = 1'b1;
                            capture    = 1'b1;
                            state_d    = e_stream;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else if (l15_ret_type_i == inv_ret_lp) begin
                        inv_capture = 1'b1;
                        state_d     = e_inv;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            e_stream: begin
                resp_v_o = 1'b1;
                if (resp_ready_and_i && last_beat) begin
                    state_d = e_idle;
                end
            end
            e_inv: begin
                inv_v_o = 1'b1;
                if (inv_ready_and_i) begin
                    state_d = e_idle;
                end
            end
            default: state_d = e_idle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= e_idle;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            beat_q     <= '0;
            last_idx_q <= '0;
            data_q     <= '0;
            addr_q     <= '0;
            size_q     <= '0;
            type_q     <= '0;
            inv_addr_q <= '0;
        end else begin
            if (capture) begin
                beat_q     <= '0;
                last_idx_q <= last_idx_d;
                data_q     <= l15_ret_data_i;
                addr_q     <= hdr_addr_i;
                size_q     <= hdr_size_i;
                type_q     <= l15_ret_type_i;
            end else if (streaming && resp_ready_and_i) begin
                beat_q <= last_beat ? '0 : beat_q + 1'b1;
            end
            if (inv_capture) begin
                inv_addr_q <= l15_ret_inv_addr_i;
            end
        end
    end

    assign ack_only    = (type_q == st_ack_lp);
    assign single_load = (type_q == load_ret_lp) && (last_idx_q == '0);
    // A single-beat load picks the 64-bit lane addressed within the 128-bit dcache line
    assign lane        = single_load ? cnt_width_lp'(addr_q[3]) : beat_q;

    assign resp_addr_o     = streaming ? addr_q + paddr_width_p'({beat_q, 3'b000}) : '0;
    assign resp_size_o     = streaming ? size_q : '0;
    assign resp_data_o     = (streaming && !ack_only) ? data_q[lane] : '0;
    assign resp_last_o     = streaming && last_beat;
    assign resp_ack_only_o = streaming && ack_only;
    assign inv_addr_o      = (state_q == e_inv) ? inv_addr_q : '0;
    assign err_o           = err_q;

endmodule
